// File: rtl/run_controller_if.sv
// Handshake bundle between the bench pins and run_controller.
// master: bench side (drives start/halt); slave: controller side.
interface run_controller_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic             halt;
  logic             core_clear;
  logic             pc_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, halt,
    input  core_clear, pc_en, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, halt,
    output core_clear, pc_en, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/run_controller.sv
// run_controller: START/HOLD/PROGRAM sequencer for the 9-bit-ISA core.
// Clears the core, holds while start is high, enables PC/architectural writes
// until halt, then reports done. Counts RUN cycles (saturating).
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to end a run after MAX_CYCLES
// RUN cycles with timeout set; otherwise timeout is tied low.
module run_controller #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,  // synchronous, active low
  run_controller_if.slave   bus
);

  localparam int unsigned     ClrW    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StHold,
    StRun,
    StDone
  } state_e;

  state_e            state_q;
  logic [ClrW-1:0]   clr_cnt_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [CNT_W-1:0]  cycle_count_inc;

  // Saturating increment of the RUN cycle counter.
  always_comb begin
    cycle_count_inc = cycle_count_q;
    if (cycle_count_q != CntMax) begin
      cycle_count_inc = cycle_count_q + 1'b1;
    end
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  logic timeout_q;
  logic wd_hit;
  // Watchdog fires on the edge that would make the count reach MAX_CYCLES.
  assign wd_hit = ((32'(cycle_count_q) + 32'd1) == 32'(MAX_CYCLES));
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  // Sequencer state, clear counter, cycle counter and timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      clr_cnt_q     <= '0;
      cycle_count_q <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        StClear: begin
          // start is deliberately ignored until the clear completes
          if (clr_cnt_q == ClrLast) begin
            state_q <= StHold;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (!bus.start) begin
            state_q       <= StRun;
            cycle_count_q <= '0;
          end
        end
        StRun: begin
          // Every RUN edge counts, including the halting/aborting one.
          cycle_count_q <= cycle_count_inc;
          if (bus.start) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end else if (bus.halt) begin
            state_q <= StDone;
`ifdef RUN_CTRL_WATCHDOG_EN
          end else if (wd_hit) begin
            state_q       <= StDone;
            timeout_q     <= 1'b1;
            cycle_count_q <= CNT_W'(MAX_CYCLES);
`endif
          end
        end
        StDone: begin
          if (bus.start) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  assign bus.core_clear  = (state_q == StClear);
  assign bus.pc_en       = (state_q == StRun);
  assign bus.busy        = (state_q == StClear) || (state_q == StHold) || (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.cycle_count = cycle_count_q;
`ifdef RUN_CTRL_WATCHDOG_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: two instances (16-bit counter and a
// 4-bit counter with MAX_CYCLES=8) share the same start/halt/reset stimulus.
module tb_run_controller;

  localparam int Clr = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halt  = 1'b0;

  always #5 clk = ~clk;

  run_controller_if #(.CNT_W(16)) bus_a ();
  run_controller_if #(.CNT_W(4))  bus_b ();

  assign bus_a.start = start;
  assign bus_a.halt  = halt;
  assign bus_b.start = start;
  assign bus_b.halt  = halt;

  run_controller #(.CNT_W(16), .CLR_CYCLES(Clr), .MAX_CYCLES(16'hFFFF)) u_dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  run_controller #(.CNT_W(4), .CLR_CYCLES(Clr), .MAX_CYCLES(8)) u_dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  // Behavioural model: phase flags plus counters, no state encoding.
  typedef struct {
    bit clearing;
    int clear_left;
    bit holding;
    bit running;
    bit finished;
    int count;
    bit to;
  } mdl_t;

  typedef struct {
    logic [4:0] flags;  // core_clear, pc_en, busy, done, timeout
    int         count;
    string      tag;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic mdl_t step(mdl_t m, bit rn, bit st, bit ht, int cnt_max, int max_cycles);
    mdl_t n;
    bit   wd;
`ifdef RUN_CTRL_WATCHDOG_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif
    n = m;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    if (m.clearing) begin
      n.clear_left = m.clear_left - 1;
      if (n.clear_left == 0) begin
        n.clearing = 0;
        n.holding  = 1;
      end
    end else if (m.holding) begin
      if (!st) begin
        n.holding = 0;
        n.running = 1;
        n.count   = 0;
      end
    end else if (m.running) begin
      n.count = (m.count < cnt_max) ? m.count + 1 : cnt_max;
      if (st) begin
        n.running    = 0;
        n.clearing   = 1;
        n.clear_left = Clr;
      end else if (ht) begin
        n.running  = 0;
        n.finished = 1;
      end else if (wd && (m.count + 1 == max_cycles)) begin
        n.running  = 0;
        n.finished = 1;
        n.to       = 1;
        n.count    = max_cycles;
      end
    end else if (m.finished) begin
      if (st) begin
        n.finished   = 0;
        n.clearing   = 1;
        n.clear_left = Clr;
        n.to         = 0;
      end
    end else if (st) begin
      n.clearing   = 1;
      n.clear_left = Clr;
    end
    return n;
  endfunction

  function automatic exp_t expect_of(mdl_t m, string tag);
    exp_t e;
    e.flags = {m.clearing, m.running, m.clearing | m.holding | m.running, m.finished, m.to};
    e.count = m.count;
    e.tag   = tag;
    return e;
  endfunction

  // Apply one cycle of stimulus and queue the model's post-edge outputs.
  task automatic tick(bit rn, bit st, bit ht, string tag);
    @(negedge clk);
    rst_n = rn;
    start = st;
    halt  = ht;
    ma = step(ma, rn, st, ht, 65535, 65535);
    mb = step(mb, rn, st, ht, 15, 8);
    qa.push_back(expect_of(ma, tag));
    qb.push_back(expect_of(mb, tag));
  endtask

  task automatic idle_cycles(int n, bit st, bit ht, string tag);
    for (int i = 0; i < n; i++) tick(1'b1, st, ht, tag);
  endtask

  // Monitor: one comparison per instance per cycle, just after the edge.
  initial begin
    exp_t e;
    logic [4:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e   = qa.pop_front();
        got = {bus_a.core_clear, bus_a.pc_en, bus_a.busy, bus_a.done, bus_a.timeout};
        n_tests++;
        if (got !== e.flags || int'(bus_a.cycle_count) != e.count) begin
          n_fail++;
          $display("FAIL %s dut_a: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                   e.tag, got, bus_a.cycle_count, e.flags, e.count);
        end
      end
      if (qb.size() > 0) begin
        e   = qb.pop_front();
        got = {bus_b.core_clear, bus_b.pc_en, bus_b.busy, bus_b.done, bus_b.timeout};
        n_tests++;
        if (got !== e.flags || int'(bus_b.cycle_count) != e.count) begin
          n_fail++;
          $display("FAIL %s dut_b: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                   e.tag, got, bus_b.cycle_count, e.flags, e.count);
        end
      end
    end
  end

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset with random start/halt, then idle with start low.
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset");
    end
    idle_cycles(3, 1'b0, 1'b0, "idle");

    // Start held 5 cycles, halt on the 10th pc_en cycle.
    idle_cycles(5, 1'b1, 1'b0, "start_hold");
    idle_cycles(10, 1'b0, 1'b0, "run10");
    idle_cycles(1, 1'b0, 1'b1, "halt10");
    idle_cycles(2, 1'b0, 1'b0, "done10");

    // Restart from DONE.
    idle_cycles(1, 1'b1, 1'b0, "restart");
    idle_cycles(7, 1'b0, 1'b0, "rerun");
    idle_cycles(1, 1'b0, 1'b1, "rehalt");
    idle_cycles(1, 1'b0, 1'b0, "redone");

    // start and halt together in RUN: abort wins.
    idle_cycles(1, 1'b1, 1'b0, "abort_go");
    idle_cycles(5, 1'b0, 1'b0, "abort_run");
    idle_cycles(1, 1'b1, 1'b1, "abort_both");
    idle_cycles(6, 1'b0, 1'b0, "abort_after");
    idle_cycles(1, 1'b0, 1'b1, "abort_halt");

    // Reset during the 3rd RUN cycle.
    idle_cycles(1, 1'b1, 1'b0, "mid_go");
    idle_cycles(5, 1'b0, 1'b0, "mid_run");
    tick(1'b0, 1'b0, 1'b0, "mid_reset");
    idle_cycles(2, 1'b0, 1'b1, "mid_idle");

    // Long run with halt low: watchdog or saturation on dut_b.
    idle_cycles(1, 1'b1, 1'b0, "long_go");
    idle_cycles(25, 1'b0, 1'b0, "long_run");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 5) == 0), "random");
    end

    // Drain.
    repeat (3) @(negedge clk);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
